// File: rtl/elevator_car_pkg.sv
// Shared definitions for the elevator car: state encoding, floor geometry,
// direction codes and the timer width used by the travel/door counter.
package elevator_car_pkg;

    localparam int NUM_FLOORS = 8;
    localparam int FLOOR_W    = 3;
    localparam int TIMER_W    = 8;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam logic [FLOOR_W-1:0] BOTTOM_FLOOR = '0;
    localparam logic [FLOOR_W-1:0] TOP_FLOOR    = FLOOR_W'(NUM_FLOORS - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_MOVING    = 2'd1,
        ST_DOOR_OPEN = 2'd2
    } car_state_e;

    // True when the car cannot travel any further in the given direction.
    function automatic logic at_end_floor(input logic [FLOOR_W-1:0] floor,
                                          input logic dir);
        return (dir == DIR_UP) ? (floor == TOP_FLOOR) : (floor == BOTTOM_FLOOR);
    endfunction

endpackage

// File: rtl/elevator_car_cycle_timer.sv
// Loadable down-counter with a zero flag. The car uses a single instance for
// both the per-floor travel time and the door-open time, since the two never
// overlap.
module elevator_car_cycle_timer
    import elevator_car_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               load_i,
    input  logic [TIMER_W-1:0] value_i,
    input  logic               dec_i,
    output logic               zero_o
);

    logic [TIMER_W-1:0] count_q;
    logic [TIMER_W-1:0] count_d;

    // Load wins over decrement; decrement saturates at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = value_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - TIMER_W'(1);
        end
    end

    // Counter register, cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/elevator_car.sv
// Single elevator car: idles, travels floor by floor at a fixed rate, and
// opens its door for a fixed time when it stops at a called floor.
module elevator_car
    import elevator_car_pkg::*;
#(
    parameter int TRAVEL_CYCLES = 8,
    parameter int DOOR_CYCLES   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  should_move,
    input  logic                  direction,
    input  logic [NUM_FLOORS-1:0] call_inside,
    input  logic [NUM_FLOORS-1:0] call_up,
    input  logic [NUM_FLOORS-1:0] call_down,
    output logic [FLOOR_W-1:0]    cur_floor,
    output logic                  floor_reached,
    output logic                  door_open,
    output logic                  moving,
    output logic                  travel_dir
);

    localparam logic [TIMER_W-1:0] TRAVEL_LOAD = TIMER_W'(TRAVEL_CYCLES - 1);
    localparam logic [TIMER_W-1:0] DOOR_LOAD   = TIMER_W'(DOOR_CYCLES - 1);

    car_state_e         state_q;
    car_state_e         state_d;
    logic [FLOOR_W-1:0] floor_q;
    logic [FLOOR_W-1:0] floor_d;
    logic               dir_q;
    logic               dir_d;
    logic               pulse_q;
    logic               pulse_d;

    logic               timer_load;
    logic [TIMER_W-1:0] timer_value;
    logic               timer_dec;
    logic               timer_zero;

    logic [NUM_FLOORS-1:0] calls;
    logic                  call_here;
    logic                  can_step;
    logic [FLOOR_W-1:0]    step_floor;
    logic [FLOOR_W-1:0]    next_floor;
    logic                  call_next;

    // Any kind of call at a floor counts as a reason to stop there.
    assign calls      = call_inside | call_up | call_down;
    assign call_here  = calls[floor_q];
    assign can_step   = !at_end_floor(floor_q, dir_q);
    assign step_floor = (dir_q == DIR_UP) ? (floor_q + FLOOR_W'(1)) : (floor_q - FLOOR_W'(1));
    assign next_floor = can_step ? step_floor : floor_q;
    assign call_next  = can_step && calls[step_floor];

    elevator_car_cycle_timer u_cycle_timer (
        .clk_i   (clk),
        .rst_ni  (reset),
        .load_i  (timer_load),
        .value_i (timer_value),
        .dec_i   (timer_dec),
        .zero_o  (timer_zero)
    );

    // Next-state logic: decides departures, floor steps, stops and door closing.
    always_comb begin
        state_d     = state_q;
        floor_d     = floor_q;
        dir_d       = dir_q;
        pulse_d     = 1'b0;
        timer_load  = 1'b0;
        timer_value = '0;
        timer_dec   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (call_here) begin
                    state_d     = ST_DOOR_OPEN;
                    timer_load  = 1'b1;
                    timer_value = DOOR_LOAD;
                    pulse_d     = 1'b1;
                end else if (should_move && !at_end_floor(floor_q, direction)) begin
                    state_d     = ST_MOVING;
                    dir_d       = direction;
                    timer_load  = 1'b1;
                    timer_value = TRAVEL_LOAD;
                end
            end

            ST_MOVING: begin
                if (!timer_zero) begin
                    timer_dec = 1'b1;
                end else begin
                    floor_d = next_floor;
                    if (call_next) begin
                        state_d     = ST_DOOR_OPEN;
                        timer_load  = 1'b1;
                        timer_value = DOOR_LOAD;
                        pulse_d     = 1'b1;
                    end else if (should_move && (direction == dir_q) &&
                                 !at_end_floor(next_floor, dir_q)) begin
                        timer_load  = 1'b1;
                        timer_value = TRAVEL_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_DOOR_OPEN: begin
                if (!timer_zero) begin
                    timer_dec = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, position, latched direction and arrival pulse registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            floor_q <= BOTTOM_FLOOR;
            dir_q   <= DIR_UP;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            floor_q <= floor_d;
            dir_q   <= dir_d;
            pulse_q <= pulse_d;
        end
    end

    assign cur_floor     = floor_q;
    assign floor_reached = pulse_q;
    assign door_open     = (state_q == ST_DOOR_OPEN);
    assign moving        = (state_q == ST_MOVING);
    assign travel_dir    = dir_q;

endmodule

// File: tb/tb_elevator_car.sv
// Self-checking bench for elevator_car: directed scenarios plus a randomized
// run compared against a behavioural model of the car.
module tb_elevator_car;

    localparam int TRAVEL = 4;
    localparam int DOOR   = 3;

    localparam int M_REST   = 0;
    localparam int M_TRAVEL = 1;
    localparam int M_DOOR   = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       shouldMove;
    logic       direction;
    logic [7:0] callInside;
    logic [7:0] callUp;
    logic [7:0] callDown;
    logic [2:0] curFloor;
    logic       floorReached;
    logic       doorOpen;
    logic       moving;
    logic       travelDir;

    int errorCount = 0;
    int checkCount = 0;

    int mMode;
    int mLeft;
    int mFloor;
    logic mDir;
    logic mPulse;

    elevator_car #(
        .TRAVEL_CYCLES (TRAVEL),
        .DOOR_CYCLES   (DOOR)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .should_move   (shouldMove),
        .direction     (direction),
        .call_inside   (callInside),
        .call_up       (callUp),
        .call_down     (callDown),
        .cur_floor     (curFloor),
        .floor_reached (floorReached),
        .door_open     (doorOpen),
        .moving        (moving),
        .travel_dir    (travelDir)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic sm, input logic dir, input logic [7:0] ci,
                                 input logic [7:0] cu, input logic [7:0] cd);
        shouldMove = sm;
        direction  = dir;
        callInside = ci;
        callUp     = cu;
        callDown   = cd;
    endtask

    function automatic void modelReset();
        mMode  = M_REST;
        mLeft  = 0;
        mFloor = 0;
        mDir   = 1'b1;
        mPulse = 1'b0;
    endfunction

    // One clock edge of the car, phrased as "cycles left in the current phase".
    function automatic void modelStep(input logic sm, input logic dir, input logic [7:0] calls);
        mPulse = 1'b0;
        if (mMode == M_REST) begin
            if (calls[mFloor]) begin
                mMode = M_DOOR; mLeft = DOOR; mPulse = 1'b1;
            end else if (sm && !(dir && mFloor == 7) && !(!dir && mFloor == 0)) begin
                mMode = M_TRAVEL; mLeft = TRAVEL; mDir = dir;
            end
        end else if (mMode == M_TRAVEL) begin
            mLeft--;
            if (mLeft == 0) begin
                mFloor = mDir ? mFloor + 1 : mFloor - 1;
                if (calls[mFloor]) begin
                    mMode = M_DOOR; mLeft = DOOR; mPulse = 1'b1;
                end else if (sm && dir == mDir && mFloor >= 1 && mFloor <= 6) begin
                    mLeft = TRAVEL;
                end else begin
                    mMode = M_REST;
                end
            end
        end else begin
            mLeft--;
            if (mLeft == 0) mMode = M_REST;
        end
    endfunction

    task automatic doReset();
        @(posedge clk);
        #3;
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        modelReset();
        #4;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        logic [6:0] got;
        doReset();
        applyStimulus(1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
        repeat (7) @(posedge clk);
        #1;
        checkCount++;
        if (curFloor !== 3'd1 || moving !== 1'b1) begin
            errorCount++;
            $display("[TB] FAIL pre_reset_travel: floor=%0d moving=%b expected floor=1 moving=1", curFloor, moving);
        end
        #2 reset = 1'b0;
        #1;
        got = {curFloor, floorReached, doorOpen, moving, travelDir};
        checkCount++;
        if (got !== 7'b000_0001) begin
            errorCount++;
            $display("[TB] FAIL async_reset: got %b expected 0000001", got);
        end
        #10;
        got = {curFloor, floorReached, doorOpen, moving, travelDir};
        checkCount++;
        if (got !== 7'b000_0001) begin
            errorCount++;
            $display("[TB] FAIL reset_held: got %b expected 0000001", got);
        end
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        got = {curFloor, floorReached, doorOpen, moving, travelDir};
        checkCount++;
        if (got !== 7'b000_0011) begin
            errorCount++;
            $display("[TB] FAIL first_edge_after_reset: got %b expected 0000011", got);
        end
    endtask

    task automatic test_door_here();
        doReset();
        applyStimulus(1'b0, 1'b0, 8'h01, 8'h00, 8'h00);
        @(posedge clk);
        #1;
        checkCount++;
        if (floorReached !== 1'b1 || doorOpen !== 1'b1) begin
            errorCount++;
            $display("[TB] FAIL door_here_open: pulse=%b door=%b expected 1 1", floorReached, doorOpen);
        end
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            checkCount++;
            if (floorReached !== 1'b0 || doorOpen !== 1'b1) begin
                errorCount++;
                $display("[TB] FAIL door_here_hold: pulse=%b door=%b expected 0 1", floorReached, doorOpen);
            end
        end
        @(posedge clk);
        #1;
        checkCount++;
        if (doorOpen !== 1'b0 || moving !== 1'b0 || floorReached !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL door_here_close: door=%b moving=%b pulse=%b expected 0 0 0", doorOpen, moving, floorReached);
        end
    endtask

    task automatic test_travel_up();
        int arrive [4];
        int pulseCycle;
        int pulses;
        int doorCycles;
        for (int i = 0; i < 4; i++) arrive[i] = -1;
        pulseCycle = -1;
        pulses = 0;
        doorCycles = 0;
        doReset();
        applyStimulus(1'b1, 1'b1, 8'h00, 8'h08, 8'h00);
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk);
            #1;
            if (curFloor <= 3'd3 && arrive[curFloor] < 0) arrive[curFloor] = cyc;
            if (floorReached) begin pulses++; pulseCycle = cyc; end
            if (doorOpen) break;
        end
        checkCount++;
        if (arrive[1] != 5 || arrive[2] != 9 || arrive[3] != 13) begin
            errorCount++;
            $display("[TB] FAIL travel_timing: arrivals %0d %0d %0d expected 5 9 13", arrive[1], arrive[2], arrive[3]);
        end
        checkCount++;
        if (pulses != 1 || pulseCycle != 13) begin
            errorCount++;
            $display("[TB] FAIL travel_pulse: count=%0d at=%0d expected 1 at 13", pulses, pulseCycle);
        end
        applyStimulus(1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
        if (doorOpen) doorCycles = 1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (doorOpen) doorCycles++;
        end
        checkCount++;
        if (doorCycles != 3 || curFloor !== 3'd3 || moving !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL travel_door: doorCycles=%0d floor=%0d moving=%b expected 3 3 0", doorCycles, curFloor, moving);
        end
    endtask

    task automatic test_bottom_hold();
        doReset();
        applyStimulus(1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            checkCount++;
            if (moving !== 1'b0 || curFloor !== 3'd0) begin
                errorCount++;
                $display("[TB] FAIL bottom_hold: moving=%b floor=%0d expected 0 0", moving, curFloor);
            end
        end
    endtask

    task automatic test_drop_move();
        int pulses;
        pulses = 0;
        doReset();
        applyStimulus(1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(posedge clk);
            #1;
            if (floorReached) pulses++;
            if (cyc == 10) applyStimulus(1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
            if (cyc == 12) begin
                checkCount++;
                if (curFloor !== 3'd2 || moving !== 1'b1) begin
                    errorCount++;
                    $display("[TB] FAIL drop_mid_segment: floor=%0d moving=%b expected 2 1", curFloor, moving);
                end
            end
            if (cyc == 13) begin
                checkCount++;
                if (curFloor !== 3'd3 || moving !== 1'b0 || doorOpen !== 1'b0) begin
                    errorCount++;
                    $display("[TB] FAIL drop_arrival: floor=%0d moving=%b door=%b expected 3 0 0", curFloor, moving, doorOpen);
                end
            end
        end
        checkCount++;
        if (pulses != 0 || curFloor !== 3'd3) begin
            errorCount++;
            $display("[TB] FAIL drop_no_pulse: pulses=%0d floor=%0d expected 0 3", pulses, curFloor);
        end
    endtask

    task automatic test_top_floor();
        int pulses;
        int pulseCycle;
        int maxFloor;
        int badStep;
        int prevFloor;
        pulses = 0; pulseCycle = -1; maxFloor = 0; badStep = 0; prevFloor = 0;
        doReset();
        applyStimulus(1'b1, 1'b1, 8'h00, 8'h00, 8'h80);
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(posedge clk);
            #1;
            if (int'(curFloor) > maxFloor) maxFloor = int'(curFloor);
            if (int'(curFloor) != prevFloor && int'(curFloor) != prevFloor + 1) badStep++;
            prevFloor = int'(curFloor);
            if (floorReached) begin
                pulses++;
                pulseCycle = cyc;
                applyStimulus(1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
            end
        end
        checkCount++;
        if (pulses != 1 || pulseCycle != 29) begin
            errorCount++;
            $display("[TB] FAIL top_pulse: count=%0d at=%0d expected 1 at 29", pulses, pulseCycle);
        end
        checkCount++;
        if (curFloor !== 3'd7 || maxFloor != 7 || badStep != 0 || moving !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL top_no_wrap: floor=%0d max=%0d badSteps=%0d moving=%b expected 7 7 0 0", curFloor, maxFloor, badStep, moving);
        end
    endtask

    task automatic test_reopen();
        logic [15:0] pulseMask;
        logic [15:0] doorMask;
        pulseMask = '0;
        doorMask = '0;
        doReset();
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h01, 8'h00);
        for (int cyc = 1; cyc <= 9; cyc++) begin
            @(posedge clk);
            #1;
            pulseMask[cyc] = floorReached;
            doorMask[cyc]  = doorOpen;
        end
        checkCount++;
        if (pulseMask !== 16'h0222) begin
            errorCount++;
            $display("[TB] FAIL reopen_pulses: got %h expected 0222", pulseMask);
        end
        checkCount++;
        if (doorMask !== 16'h02EE) begin
            errorCount++;
            $display("[TB] FAIL reopen_door: got %h expected 02ee", doorMask);
        end
    endtask

    task automatic test_random();
        logic       wantDir;
        int         sel;
        int         fl;
        logic [6:0] expVec;
        logic [6:0] gotVec;
        doReset();
        wantDir = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 249) == 0) begin
                #2 reset = 1'b0;
                #1;
                gotVec = {curFloor, floorReached, doorOpen, moving, travelDir};
                checkCount++;
                if (gotVec !== 7'b000_0001) begin
                    errorCount++;
                    $display("[TB] FAIL random_reset: cycle %0d got %b expected 0000001", cyc, gotVec);
                end
                modelReset();
                #2 reset = 1'b1;
            end
            if ($urandom_range(0, 19) == 0) wantDir = ~wantDir;
            if ($urandom_range(0, 9) == 0) begin
                sel = $urandom_range(0, 2);
                fl  = $urandom_range(0, 7);
                case (sel)
                    0:       callInside[fl] = 1'b1;
                    1:       callUp[fl]     = 1'b1;
                    default: callDown[fl]   = 1'b1;
                endcase
            end
            shouldMove = ($urandom_range(0, 3) != 0);
            direction  = wantDir;
            @(posedge clk);
            modelStep(shouldMove, direction, callInside | callUp | callDown);
            #1;
            expVec = {3'(mFloor), mPulse, (mMode == M_DOOR), (mMode == M_TRAVEL), mDir};
            gotVec = {curFloor, floorReached, doorOpen, moving, travelDir};
            checkCount++;
            if (gotVec !== expVec) begin
                errorCount++;
                $display("[TB] FAIL random_cycle: cycle %0d got %b expected %b", cyc, gotVec, expVec);
            end
            if (mPulse) begin
                callInside[mFloor] = 1'b0;
                callUp[mFloor]     = 1'b0;
                callDown[mFloor]   = 1'b0;
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        modelReset();
        test_reset();
        test_door_here();
        test_travel_up();
        test_bottom_hold();
        test_drop_move();
        test_top_floor();
        test_reopen();
        test_random();
        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/elevator_car.md
ELEVATOR_CAR -- requirements
Module: elevator_car

Interface
REQ-001 Parameter TRAVEL_CYCLES, default 8, clock cycles to travel one floor (legal 1..255).
REQ-002 Parameter DOOR_CYCLES, default 4, clock cycles the door stays open (legal 1..255).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 should_move  input  1  controller request to travel.
REQ-006 direction  input  1  requested travel direction: 1 = up, 0 = down.
REQ-007 call_inside, call_up, call_down  input  8 each  pending-call vectors, bit n = floor n.
REQ-008 cur_floor  output  3  registered current floor, 0..7.
REQ-009 floor_reached  output  1  one-cycle pulse when the car stops at a called floor.
REQ-010 door_open  output  1  high while in DOOR_OPEN.
REQ-011 moving  output  1  high while in MOVING.
REQ-012 travel_dir  output  1  direction latched at departure; held when not moving.

Function
REQ-013 States: IDLE, MOVING, DOOR_OPEN; one 8-bit down-counter shared by travel and door timing.
REQ-014 call_here = OR of call_inside, call_up, call_down at bit cur_floor; call_next uses bit cur_floor+1 (travel_dir=1) or cur_floor-1 (travel_dir=0).
REQ-015 IDLE, call_here=1: next edge -> DOOR_OPEN, counter = DOOR_CYCLES-1, floor_reached=1 for that cycle; takes priority over should_move.
REQ-016 IDLE, call_here=0, should_move=1, not at end floor in requested direction: next edge -> MOVING, travel_dir = direction, counter = TRAVEL_CYCLES-1.
REQ-017 IDLE, should_move=1 with direction=1 at floor 7 or direction=0 at floor 0: remain IDLE, cur_floor unchanged.
REQ-018 MOVING, counter>0: counter decrements; direction and should_move ignored (no mid-segment stop or reversal).
REQ-019 MOVING, counter=0: next edge cur_floor steps by +1/-1 per travel_dir; exactly TRAVEL_CYCLES cycles per floor.
REQ-020 Same edge, call_next=1: -> DOOR_OPEN, counter = DOOR_CYCLES-1, floor_reached=1 for one cycle.
REQ-021 Same edge, call_next=0, should_move=1, direction=travel_dir, new floor not an end floor: stay MOVING, reload TRAVEL_CYCLES-1.
REQ-022 Same edge, any other case (should_move dropped, direction reversed, end floor reached): -> IDLE, no floor_reached pulse.
REQ-023 DOOR_OPEN: counter decrements; at counter=0 next edge -> IDLE; all inputs ignored until then.
REQ-024 floor_reached is never high for two consecutive cycles; a DOOR_OPEN -> IDLE -> DOOR_OPEN re-entry on a still-pending call produces a new pulse.
REQ-025 cur_floor never wraps: no step above 7 or below 0 under any input.

Reset
REQ-026 reset low: immediately, independent of clk, state=IDLE, cur_floor=0, counter=0, floor_reached=0, door_open=0, moving=0, travel_dir=1.
REQ-027 Reset mid-travel or mid-door abandons the operation; no partial floor step or pulse follows release.
REQ-028 First state change occurs on the first rising edge after reset returns high.

Structure
REQ-029 Shared package holds state encoding, DIR_UP=1/DIR_DOWN=0, NUM_FLOORS=8, FLOOR_W=3.
REQ-030 One sub-module, cycle_timer: loadable 8-bit down-counter with zero flag, used for both travel and door timing.

Verification (TRAVEL_CYCLES=4, DOOR_CYCLES=3)
REQ-031 Reset low mid-run -> all outputs at REQ-026 values within same cycle; cur_floor=0.
REQ-032 IDLE at floor 0, call_inside=8'h01 -> floor_reached pulse 1 cycle, door_open high 3 cycles, then IDLE.
REQ-033 should_move=1, direction=1, call_up=8'h08 -> cur_floor 0->1->2->3 every 4 cycles; at 3 floor_reached pulse, door_open 3 cycles.
REQ-034 At floor 0, should_move=1, direction=0, no calls -> stays IDLE, moving=0, cur_floor=0 indefinitely.
REQ-035 From floor 2 moving up, drop should_move 1 cycle after departure -> arrives floor 3 after 4 cycles, IDLE, no floor_reached.
REQ-036 Moving up, call_down=8'h80 with should_move held -> reaches floor 7, pulse, door opens; no step past 7.
